fifo_mc: RTL and testbench

Parametrised multi-channel FIFO and the successor to the single-queue FIFO. It holds NUM_CH independent queues of DEPTH words each, with one shared write port and one shared read port, each selected by a channel index. It provides per-channel empty/full/almost flags, pause flow control with hysteresis, and error flagging. It sits between the demux/classifier stage and the downstream arbiter, which uses the pause/empty vectors to schedule reads.

---
 rtl/fifo_mc.sv | 152 +++++++++++++++
 tb/tb_fifo_mc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mc.sv
// Purpose: NUM_CH independent FIFO queues sharing one write port and one read port, with per-channel flags, pause and error vectors.
// Latency: one cycle from an accepted read strobe to data_out/valid_out; occupancy flags react combinationally to the counts.
// Backpressure: writes to a full channel are dropped and flagged; the arbiter schedules reads from pause_vec/empty_vec.
// Optional build macro FIFO_MC_ERR_STICKY_EN: when defined, error flags latch until err_clr; otherwise they pulse for one cycle.
module fifo_mc #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_W    = 2,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 write,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 read,
    input  logic [CH_W-1:0]      rd_ch,
    input  logic [ADDR_W:0]      umb_almost_full,
    input  logic [ADDR_W:0]      umb_almost_empty,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [NUM_CH-1:0]    empty_vec,
    output logic [NUM_CH-1:0]    full_vec,
    output logic [NUM_CH-1:0]    almost_full_vec,
    output logic [NUM_CH-1:0]    almost_empty_vec,
    output logic [NUM_CH-1:0]    pause_vec,
    output logic [NUM_CH-1:0]    error_vec
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem    [NUM_CH][DEPTH];
    logic [ADDR_W-1:0]    wr_ptr [NUM_CH];
    logic [ADDR_W-1:0]    rd_ptr [NUM_CH];
    logic [ADDR_W:0]      cnt    [NUM_CH];

    logic              wr_hit, rd_hit, wr_ok, rd_ok;
    logic [NUM_CH-1:0] wr_sel, rd_sel, new_err;

    // Occupancy flags decoded straight from each channel's count.
    always_comb begin
        empty_vec        = '0;
        full_vec         = '0;
        almost_full_vec  = '0;
        almost_empty_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty_vec[c]        = (cnt[c] == '0);
            full_vec[c]         = (cnt[c] == FULL_CNT);
            almost_full_vec[c]  = (cnt[c] >= umb_almost_full);
            almost_empty_vec[c] = (cnt[c] <= umb_almost_empty) && (cnt[c] != '0);
        end
    end

    // Accept/reject decode; out-of-range channel indices are silently ignored.
    always_comb begin
        wr_hit  = write && (int'(wr_ch) < NUM_CH);
        rd_hit  = read  && (int'(rd_ch) < NUM_CH);
        wr_ok   = wr_hit && !full_vec[wr_ch];
        rd_ok   = rd_hit && !empty_vec[rd_ch];
        wr_sel  = '0;
        rd_sel  = '0;
        new_err = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_sel[c] = wr_ok && (wr_ch == CH_W'(c));
            rd_sel[c] = rd_ok && (rd_ch == CH_W'(c));
            if (wr_hit && full_vec[wr_ch] && (wr_ch == CH_W'(c)))
                new_err[c] = 1'b1;
            if (rd_hit && empty_vec[rd_ch] && (rd_ch == CH_W'(c)))
                new_err[c] = 1'b1;
        end
    end

    // Storage array; contents need no reset because the counts gate every read.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ch][wr_ptr[wr_ch]] <= data_in;
    end

    // Per-channel pointers and counts; simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_sel[c])
                    wr_ptr[c] <= wr_ptr[c] + ADDR_W'(1);
                if (rd_sel[c])
                    rd_ptr[c] <= rd_ptr[c] + ADDR_W'(1);
                case ({wr_sel[c], rd_sel[c]})
                    2'b10:   cnt[c] <= cnt[c] + (ADDR_W+1)'(1);
                    2'b01:   cnt[c] <= cnt[c] - (ADDR_W+1)'(1);
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

    // Registered read port; data_out holds its value between accepted reads.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_ok;
            if (rd_ok)
                data_out <= mem[rd_ch][rd_ptr[rd_ch]];
        end
    end

    // Pause with hysteresis: set above the high mark, clear at the low mark, hold in between.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pause_vec <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (almost_full_vec[c] && !almost_empty_vec[c])
                    pause_vec[c] <= 1'b1;
                else if (!almost_full_vec[c] && almost_empty_vec[c])
                    pause_vec[c] <= 1'b0;
            end
        end
    end

    // Error flags: a fresh error always beats a clear issued in the same cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_vec <= '0;
        end else begin
`ifdef FIFO_MC_ERR_STICKY_EN
            if (err_clr)
                error_vec <= new_err;
            else
                error_vec <= error_vec | new_err;
`else
            error_vec <= new_err;
`endif
        end
    end

`ifndef FIFO_MC_ERR_STICKY_EN
    // Pulse mode has no use for the clear input.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_fifo_mc.sv
// Directed vector table plus hand-written sequences for pointer wrap, pause hysteresis and async reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Error expectations are chosen so that sticky and pulse builds agree.
module tb_fifo_mc;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       write, read, err_clr;
    logic [1:0] wr_ch, rd_ch;
    logic [5:0] data_in;
    logic [2:0] umb_almost_full, umb_almost_empty;
    logic [5:0] data_out;
    logic       valid_out;
    logic [3:0] empty_vec, full_vec, almost_full_vec, almost_empty_vec, pause_vec, error_vec;

    int pass_cnt = 0;
    int total_cnt = 0;

    fifo_mc dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .write            (write),
        .wr_ch            (wr_ch),
        .data_in          (data_in),
        .read             (read),
        .rd_ch            (rd_ch),
        .umb_almost_full  (umb_almost_full),
        .umb_almost_empty (umb_almost_empty),
        .err_clr          (err_clr),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .empty_vec        (empty_vec),
        .full_vec         (full_vec),
        .almost_full_vec  (almost_full_vec),
        .almost_empty_vec (almost_empty_vec),
        .pause_vec        (pause_vec),
        .error_vec        (error_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] wch;
        logic [5:0] din;
        logic       rd;
        logic [1:0] rch;
        logic       clr;
        logic       vld;
        logic [5:0] dout;
        logic [3:0] emp;
        logic [3:0] ful;
        logic [3:0] err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic wr, input logic [1:0] wch, input logic [5:0] din,
                               input logic rd, input logic [1:0] rch, input logic clr,
                               input logic vld, input logic [5:0] dout, input logic [3:0] emp,
                               input logic [3:0] ful, input logic [3:0] err);
        vec_t r;
        r.wr = wr; r.wch = wch; r.din = din; r.rd = rd; r.rch = rch; r.clr = clr;
        r.vld = vld; r.dout = dout; r.emp = emp; r.ful = ful; r.err = err;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // Apply one cycle of inputs on the falling edge, then advance to just after the rising edge.
    task automatic cyc(input logic wr, input logic [1:0] wch, input logic [5:0] din,
                       input logic rd, input logic [1:0] rch, input logic clr);
        @(negedge clk);
        write = wr; wr_ch = wch; data_in = din;
        read = rd; rd_ch = rch; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dout"},  32'(data_out),  32'h0);
        chk({tag, "_vld"},   32'(valid_out), 32'h0);
        chk({tag, "_empty"}, 32'(empty_vec), 32'hF);
        chk({tag, "_full"},  32'(full_vec),  32'h0);
        chk({tag, "_pause"}, 32'(pause_vec), 32'h0);
        chk({tag, "_err"},   32'(error_vec), 32'h0);
    endtask

    logic [5:0] q[$];
    logic [5:0] exp_d;

    initial begin
        reset_L = 1'b0;
        write = 1'b0; read = 1'b0; err_clr = 1'b0;
        wr_ch = '0; rd_ch = '0; data_in = '0;
        umb_almost_full = 3'd7; umb_almost_empty = 3'd1;

        //      wr ch din    rd ch clr  vld dout   empty    full     err
        tbl.push_back(v(1,0,6'h01, 0,0,0, 0,6'h00, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,0,6'h02, 0,0,0, 0,6'h00, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,0,6'h03, 0,0,0, 0,6'h00, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,0,6'h04, 0,0,0, 0,6'h00, 4'b1110, 4'b0001, 4'b0000));
        tbl.push_back(v(1,0,6'h05, 0,0,0, 0,6'h00, 4'b1110, 4'b0001, 4'b0001));
        tbl.push_back(v(0,0,6'h00, 0,0,1, 0,6'h00, 4'b1110, 4'b0001, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,0,0, 1,6'h01, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,0,0, 1,6'h02, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,0,0, 1,6'h03, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,0,0, 1,6'h04, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 0,0,0, 0,6'h04, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,2,0, 0,6'h04, 4'b1111, 4'b0000, 4'b0100));
        tbl.push_back(v(0,0,6'h00, 0,0,1, 0,6'h04, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(v(1,1,6'h11, 0,0,0, 0,6'h04, 4'b1101, 4'b0000, 4'b0000));
        tbl.push_back(v(1,3,6'h33, 0,0,0, 0,6'h04, 4'b0101, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,3,0, 1,6'h33, 4'b1101, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,1,0, 1,6'h11, 4'b1111, 4'b0000, 4'b0000));
        tbl.push_back(v(1,0,6'h0A, 0,0,0, 0,6'h11, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,0,6'h0B, 0,0,0, 0,6'h11, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,2,6'h22, 1,2,0, 0,6'h11, 4'b1010, 4'b0000, 4'b0100));
        tbl.push_back(v(0,0,6'h00, 1,2,1, 1,6'h22, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,3,6'h31, 0,0,0, 0,6'h22, 4'b0110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,3,6'h32, 0,0,0, 0,6'h22, 4'b0110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,3,6'h33, 0,0,0, 0,6'h22, 4'b0110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,3,6'h34, 0,0,0, 0,6'h22, 4'b0110, 4'b1000, 4'b0000));
        tbl.push_back(v(1,3,6'h35, 1,3,0, 1,6'h31, 4'b0110, 4'b0000, 4'b1000));
        tbl.push_back(v(0,0,6'h00, 1,3,1, 1,6'h32, 4'b0110, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,3,0, 1,6'h33, 4'b0110, 4'b0000, 4'b0000));
        tbl.push_back(v(0,0,6'h00, 1,3,0, 1,6'h34, 4'b1110, 4'b0000, 4'b0000));
        tbl.push_back(v(1,1,6'h2C, 1,0,0, 1,6'h0A, 4'b1100, 4'b0000, 4'b0000));
        tbl.push_back(v(1,0,6'h0C, 0,0,0, 0,6'h0A, 4'b1100, 4'b0000, 4'b0000));

        // Reset state while held in reset, then release away from the rising edge.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        chk("reset_af", 32'(almost_full_vec),  32'h0);
        chk("reset_ae", 32'(almost_empty_vec), 32'h0);
        @(negedge clk);
        reset_L = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].wr, tbl[i].wch, tbl[i].din, tbl[i].rd, tbl[i].rch, tbl[i].clr);
            chk($sformatf("row%0d_vld", i),   32'(valid_out), 32'(tbl[i].vld));
            chk($sformatf("row%0d_dout", i),  32'(data_out),  32'(tbl[i].dout));
            chk($sformatf("row%0d_empty", i), 32'(empty_vec), 32'(tbl[i].emp));
            chk($sformatf("row%0d_full", i),  32'(full_vec),  32'(tbl[i].ful));
            chk($sformatf("row%0d_err", i),   32'(error_vec), 32'(tbl[i].err));
        end

        // Ch0 holds 0B,0C: ten simultaneous push/pop cycles wrap both pointers.
        q.push_back(6'h0B);
        q.push_back(6'h0C);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 2'd0, 6'(6'h20 + i), 1'b1, 2'd0, 1'b0);
            exp_d = q.pop_front();
            q.push_back(6'(6'h20 + i));
            chk($sformatf("wrap%0d_vld", i),  32'(valid_out),    32'h1);
            chk($sformatf("wrap%0d_dout", i), 32'(data_out),     32'(exp_d));
            chk($sformatf("wrap%0d_cnt2", i), 32'({full_vec[0], empty_vec[0]}), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0, 1'b0);
            exp_d = q.pop_front();
            chk($sformatf("drain%0d_dout", i), 32'(data_out), 32'(exp_d));
        end
        cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd1, 1'b0);
        chk("drain_ch1_dout", 32'(data_out),  32'h2C);
        chk("drain_empty",    32'(empty_vec), 32'hF);

        // Pause hysteresis on ch1 with high mark 3 and low mark 1.
        umb_almost_full = 3'd3;
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 6'h02, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 6'h03, 1'b0, 2'd0, 1'b0);
        chk("pause_af_at3",    32'(almost_full_vec), 32'b0010);
        chk("pause_lag_at3",   32'(pause_vec),       32'b0000);
        cyc(1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0);
        chk("pause_set_at3",   32'(pause_vec),       32'b0010);
        cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd1, 1'b0);
        chk("pause_rd_dout",   32'(data_out),        32'h01);
        cyc(1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0);
        chk("pause_hold_at2",  32'(pause_vec),       32'b0010);
        chk("pause_af_at2",    32'(almost_full_vec), 32'b0000);
        cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd1, 1'b0);
        chk("pause_ae_at1",    32'(almost_empty_vec), 32'b0010);
        chk("pause_still_1",   32'(pause_vec),        32'b0010);
        cyc(1'b0, 2'd0, 6'h00, 1'b0, 2'd0, 1'b0);
        chk("pause_clr_at1",   32'(pause_vec),        32'b0000);
        cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd1, 1'b0);
        chk("pause_last_dout", 32'(data_out),         32'h03);

        // Asynchronous reset mid-operation with ch0 partly full and a read just completed.
        umb_almost_full = 3'd7;
        cyc(1'b1, 2'd0, 6'h15, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 6'h16, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd0, 6'h17, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0, 1'b0);
        chk("pre_arst_vld",  32'(valid_out), 32'h1);
        chk("pre_arst_dout", 32'(data_out),  32'h15);
        #1;
        reset_L = 1'b0;
        #1;
        chk_reset_state("arst");
        @(negedge clk);
        reset_L = 1'b1;
        write = 1'b0; read = 1'b0; err_clr = 1'b0;
        cyc(1'b0, 2'd0, 6'h00, 1'b1, 2'd0, 1'b0);
        chk("post_arst_vld", 32'(valid_out), 32'h0);
        chk("post_arst_err", 32'(error_vec), 32'b0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
